pcm_capture: RTL and testbench
==============================

# pcm_capture

Audio capture path: the receive-side counterpart of the PCM playback channel. Samples a signed 16-bit stereo source (ADC/I2S receiver output) at a programmable decimated rate. Packs each frame into bytes (8/16-bit, mono/stereo) and pushes them into an internal byte FIFO. The CPU register interface drains the FIFO one byte per read strobe.

## Interface
- FIFO_AW, 12, FIFO address width; depth = 2^FIFO_AW bytes
- ALMOST_FULL, 3072, level at or above which fifo_almost_full is set

- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- next_sample  in  1  base-rate tick, one cycle wide, pulses ≥6 clk apart
- left_in  in  16  signed left source sample, captured on cycles where next_sample=1
- right_in  in  16  signed right source sample, captured on cycles where next_sample=1
- capture_en  in  1  1 = capture running
- sample_rate  in  8  rate divider increment (0 = stopped, 128 = every tick)
- mode_stereo  in  1  1 = store L and R; 0 = store L only
- mode_16bit  in  1  1 = 16-bit samples; 0 = upper byte only
- fifo_reset  in  1  one-cycle pulse: flush FIFO, abort frame, clear overflow
- fifo_read  in  1  pop head byte
- fifo_rddata  out  8  head byte (first-word-fall-through), valid when !fifo_empty
- fifo_empty  out  1  level == 0
- fifo_almost_full  out  1  level ≥ ALMOST_FULL
- fifo_full  out  1  level == 2^FIFO_AW
- fifo_level  out  FIFO_AW+1  bytes stored
- overflow  out  1  sticky: at least one frame dropped

## Operation
- Rate divider: 8-bit accumulator acc. When next_sample=1 and capture_en=1, acc += min(sample_rate,128) and acc[7] before the add is stored. capture_event is asserted one cycle later iff acc[7] changed. capture_en=0 holds acc at 0.
- Hold registers: left_in/right_in are copied to hold_l/hold_r on every cycle where next_sample=1, regardless of capture_en.
- Frame size N: 1 (8-bit mono), 2 (8-bit stereo or 16-bit mono), 4 (16-bit stereo).
- Byte order:
  - 8-bit: L[15:8], then R[15:8]
  - 16-bit: L[7:0], L[15:8], R[7:0], R[15:8]
- FSM states: IDLE, WR_L0, WR_L1, WR_R0, WR_R1.
  - IDLE → first write state on capture_event when free space ≥ N.
  - 8-bit modes write from WR_L1/WR_R1 only (the high bytes); WR_L0/WR_R0 are skipped.
  - Each state writes exactly one byte, then moves to the next required state, or to IDLE after the last byte.
- Mode bits are latched into the FSM on the IDLE exit. Mode changes mid-frame do not affect the current frame.
- Overflow: if free space < N at capture_event, the whole frame is dropped (no partial frames) and overflow is set. A capture_event while the FSM is not in IDLE also drops the frame and sets overflow.
- FIFO read/write:
  - fifo_read while empty is ignored.
  - Simultaneous FSM write and fifo_read: both take effect, level unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- fifo_reset:
  - Clears pointers, level and overflow.
  - Forces the FSM to IDLE; bytes of the aborted frame are not written.
  - Takes priority over any same-cycle write or read.
  - Does not clear acc.

## Timing
- Reset values (rst_n=0 at a clk edge): fifo_empty=1, fifo_full=0, fifo_almost_full=0, fifo_level=0, overflow=0, fifo_rddata=0, FSM=IDLE, acc=0, hold_l=hold_r=0.
- Capture pipeline for next_sample=1 in cycle t:
  - t: sample latched into hold registers.
  - t+1: capture_event evaluated.
  - t+2 … t+1+N: one byte written per cycle, committed at the cycle's end edge.
- Status flags reflect level after each edge. fifo_empty falls at the start of cycle t+3; fifo_level = N at t+2+N, with no reads.
- fifo_rddata updates in the cycle after a pop, or after the first write into an empty FIFO.
- overflow sets at the end of cycle t+1 of the dropped frame.
- Throughput: one capture frame per next_sample interval. Max 4 write cycles + 1 decision cycle < 6-cycle minimum tick spacing.

## Test plan
- Reset, capture_en=1, sample_rate=128, 16-bit stereo, left_in=16'h1234, right_in=16'hABCD, one tick → bytes 34,12,CD,AB in order; fifo_level=4 at t+6; fifo_empty low from t+3.
- sample_rate=64, 8-bit mono, 8 ticks with left_in=16'h8000+k → 4 bytes stored, each the upper byte of the sample from every other tick (ticks 2,4,6,8 → 80 each); sample_rate=0 → no bytes.
- FIFO_AW=3, 16-bit stereo, no reads, 3 ticks → first two frames stored (level 8, fifo_full=1), third dropped entire; overflow=1; level stays 8.
- Level 7 of 8 with 8-bit stereo event → frame dropped, overflow=1. Pop 1 byte, next event → 2 bytes stored, level 8.
- fifo_read asserted every cycle during 16-bit stereo writes → level never exceeds 1; bytes read back in order 34,12,CD,AB.
- fifo_reset pulsed in cycle t+3 of a 4-byte frame → level 0, overflow 0, FSM IDLE; the next tick captures a full frame normally. rst_n low mid-frame → all reset values next cycle.

Source files
------------

// File: rtl/pcm_capture.sv
// pcm_capture: decimating stereo PCM capture into a byte FIFO.
// A rate accumulator picks which base-rate ticks become capture events.
// Each event is packed into 1, 2 or 4 bytes by a small write FSM and
// pushed into a first-word-fall-through FIFO that the CPU drains.
module pcm_capture #(
  parameter int FIFO_AW     = 12,
  parameter int ALMOST_FULL = 3072
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_sample,
  input  logic [15:0]        left_in,
  input  logic [15:0]        right_in,
  input  logic               capture_en,
  input  logic [7:0]         sample_rate,
  input  logic               mode_stereo,
  input  logic               mode_16bit,
  input  logic               fifo_reset,
  input  logic               fifo_read,
  output logic [7:0]         fifo_rddata,
  output logic               fifo_empty,
  output logic               fifo_almost_full,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE_L   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] ONE_P = FIFO_AW'(1);
  localparam logic [31:0]      AF_TH   = 32'(ALMOST_FULL);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_L0 = 3'd1,
    WR_L1 = 3'd2,
    WR_R0 = 3'd3,
    WR_R1 = 3'd4
  } state_t;

  // Rates above 128 would let the accumulator cross bit 7 twice per tick.
  function automatic logic [7:0] clamp_rate(input logic [7:0] r);
    return (r > 8'd128) ? 8'd128 : r;
  endfunction

  // Bytes per frame for a given packing mode.
  function automatic logic [2:0] frame_bytes(input logic stereo, input logic wide);
    if (stereo && wide)      return 3'd4;
    else if (stereo || wide) return 3'd2;
    else                     return 3'd1;
  endfunction

  logic [7:0]          acc_q, acc_d;
  logic                msb_q, msb_d;
  logic                tick_q, tick_d;
  logic signed [15:0]  hold_l_q, hold_l_d;
  logic signed [15:0]  hold_r_q, hold_r_d;
  state_t              state_q, state_d;
  logic                stereo_q, stereo_d;
  logic                wide_q, wide_d;
  logic                ovf_q, ovf_d;
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    level_q, level_d;
  logic [7:0]          rddata_q, rddata_d;
  logic [7:0]          mem_q [DEPTH];

  logic                capture_event;
  logic [FIFO_AW:0]    free_space;
  logic                accept;
  logic                drop;
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                pop;

  assign capture_event = tick_q && (acc_q[7] != msb_q);
  assign free_space    = DEPTH_L - level_q;
  assign accept        = capture_event && !fifo_reset && (state_q == IDLE) &&
                         (free_space >= (FIFO_AW+1)'(frame_bytes(mode_stereo, mode_16bit)));
  assign drop          = capture_event && !fifo_reset && !accept;
  assign pop           = fifo_read && (level_q != '0) && !fifo_reset;

  // Rate divider and sample hold: acc advances on enabled ticks, hold regs on every tick.
  always_comb begin
    acc_d    = acc_q;
    msb_d    = msb_q;
    tick_d   = next_sample && capture_en;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (!capture_en) begin
      acc_d = '0;
    end else if (next_sample) begin
      msb_d = acc_q[7];
      acc_d = acc_q + clamp_rate(sample_rate);
    end
    if (next_sample) begin
      hold_l_d = left_in;
      hold_r_d = right_in;
    end
  end

  // Next-state logic; the packing mode is frozen when a frame is accepted.
  always_comb begin
    state_d  = state_q;
    stereo_d = stereo_q;
    wide_d   = wide_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = mode_16bit ? WR_L0 : WR_L1;
          stereo_d = mode_stereo;
          wide_d   = mode_16bit;
        end
      end
      WR_L0:   state_d = WR_L1;
      WR_L1:   state_d = stereo_q ? (wide_q ? WR_R0 : WR_R1) : IDLE;
      WR_R0:   state_d = WR_R1;
      WR_R1:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fifo_reset) state_d = IDLE;
  end

  // FSM outputs: one byte per non-idle state, suppressed by a flush.
  always_comb begin
    wr_en   = (state_q != IDLE) && !fifo_reset;
    wr_data = 8'h00;
    case (state_q)
      WR_L0:   wr_data = hold_l_q[7:0];
      WR_L1:   wr_data = hold_l_q[15:8];
      WR_R0:   wr_data = hold_r_q[7:0];
      WR_R1:   wr_data = hold_r_q[15:8];
      default: wr_data = 8'h00;
    endcase
  end

  // FIFO bookkeeping: pointers, level, sticky overflow and the fall-through head byte.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rddata_d = rddata_q;
    ovf_d    = ovf_q | drop;
    if (fifo_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      rddata_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ONE_P;
      if (pop)   rd_ptr_d = rd_ptr_q + ONE_P;
      if (wr_en && !pop)      level_d = level_q + ONE_L;
      else if (!wr_en && pop) level_d = level_q - ONE_L;
      // The byte being written becomes the head if the FIFO is, or is about to be, empty.
      if (wr_en && ((level_q == '0) || (pop && (level_q == ONE_L))))
        rddata_d = wr_data;
      else if (pop)
        rddata_d = mem_q[rd_ptr_q + ONE_P];
    end
  end

  // State register for control, rate divider and hold registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      msb_q    <= 1'b0;
      tick_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      state_q  <= IDLE;
      stereo_q <= 1'b0;
      wide_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rddata_q <= '0;
    end else begin
      acc_q    <= acc_d;
      msb_q    <= msb_d;
      tick_q   <= tick_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      state_q  <= state_d;
      stereo_q <= stereo_d;
      wide_q   <= wide_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rddata_q <= rddata_d;
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign fifo_rddata      = rddata_q;
  assign fifo_level       = level_q;
  assign fifo_empty       = (level_q == '0);
  assign fifo_full        = (level_q == DEPTH_L);
  assign fifo_almost_full = ({{(31-FIFO_AW){1'b0}}, level_q} >= AF_TH);
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_pcm_capture.sv
// Testbench for pcm_capture: directed scenarios plus a randomized phase,
// with a byte scoreboard filled by a transaction-level reference model.
module tb_pcm_capture;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        next_sample;
  logic [15:0] left_in, right_in;
  logic        capture_en;
  logic [7:0]  sample_rate;
  logic        mode_stereo, mode_16bit;
  logic        fifo_reset, fifo_read;
  logic [7:0]  fifo_rddata;
  logic        fifo_empty, fifo_almost_full, fifo_full;
  logic [AW:0] fifo_level;
  logic        overflow;

  always #5 clk = ~clk;

  pcm_capture #(.FIFO_AW(AW), .ALMOST_FULL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .next_sample(next_sample),
    .left_in(left_in), .right_in(right_in), .capture_en(capture_en),
    .sample_rate(sample_rate), .mode_stereo(mode_stereo), .mode_16bit(mode_16bit),
    .fifo_reset(fifo_reset), .fifo_read(fifo_read), .fifo_rddata(fifo_rddata),
    .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int macc = 0;
  bit movf = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Reference model of one tick: decimation by accumulator crossing of 128,
  // frame packing, and whole-frame drop when there is not enough room.
  task automatic model_tick();
    int old_acc;
    logic [7:0] b[$];
    if (!capture_en) return;
    old_acc = macc;
    macc = (macc + ((sample_rate > 8'd128) ? 128 : int'(sample_rate))) % 256;
    if ((old_acc >= 128) == (macc >= 128)) return;
    if (mode_16bit) begin
      b.push_back(left_in[7:0]);
      b.push_back(left_in[15:8]);
      if (mode_stereo) begin
        b.push_back(right_in[7:0]);
        b.push_back(right_in[15:8]);
      end
    end else begin
      b.push_back(left_in[15:8]);
      if (mode_stereo) b.push_back(right_in[15:8]);
    end
    if (DEPTH - exp_q.size() >= b.size()) begin
      foreach (b[i]) exp_q.push_back(b[i]);
    end else begin
      movf = 1'b1;
    end
  endtask

  task automatic tick(input logic [15:0] l, input logic [15:0] r, input bit scramble);
    left_in = l; right_in = r; next_sample = 1'b1;
    model_tick();
    @(posedge clk); #1; next_sample = 1'b0;
    @(posedge clk); #1;
    if (scramble) begin
      mode_stereo = 1'($urandom_range(0, 1));
      mode_16bit  = 1'($urandom_range(0, 1));
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_level"}, fifo_level, exp_q.size());
    chk({tag, "_empty"}, fifo_empty, exp_q.size() == 0);
    chk({tag, "_full"},  fifo_full,  exp_q.size() == DEPTH);
    chk({tag, "_afull"}, fifo_almost_full, exp_q.size() >= AF);
    chk({tag, "_ovf"},   overflow, movf);
  endtask

  task automatic drain(input string tag);
    fifo_read = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      @(posedge clk); #1;
      if (fifo_empty) break;
    end
    fifo_read = 1'b0;
    chk({tag, "_drain_empty"}, fifo_empty, 1);
    chk({tag, "_drain_leftover"}, exp_q.size(), 0);
  endtask

  task automatic flush();
    fifo_reset = 1'b1;
    @(posedge clk); #1;
    fifo_reset = 1'b0;
    exp_q.delete();
    movf = 1'b0;
  endtask

  task automatic set_en(input bit en);
    capture_en = en;
    if (!en) macc = 0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"},  fifo_empty, 1);
    chk({tag, "_full"},   fifo_full, 0);
    chk({tag, "_afull"},  fifo_almost_full, 0);
    chk({tag, "_level"},  fifo_level, 0);
    chk({tag, "_ovf"},    overflow, 0);
    chk({tag, "_rddata"}, fifo_rddata, 0);
  endtask

  // Scoreboard monitor: every accepted pop must present the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && fifo_read && !fifo_empty && !fifo_reset) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got 0x%02h, required no byte available", fifo_rddata);
        end else begin
          chk("pop_byte", fifo_rddata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lvl;
    rst_n = 1'b0; next_sample = 1'b0; left_in = '0; right_in = '0;
    capture_en = 1'b0; sample_rate = '0; mode_stereo = 1'b0; mode_16bit = 1'b0;
    fifo_reset = 1'b0; fifo_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;

    // 16-bit stereo single frame with cycle-accurate level/empty checks
    capture_en = 1'b1; sample_rate = 8'd128; mode_16bit = 1'b1; mode_stereo = 1'b1;
    @(posedge clk); #1;
    left_in = 16'h1234; right_in = 16'hABCD; next_sample = 1'b1;
    model_tick();
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp_lvl = (k >= 3) ? k - 2 : 0;
      chk("t1_level_timing", fifo_level, exp_lvl);
      chk("t1_empty_timing", fifo_empty, exp_lvl == 0);
      @(posedge clk); #1;
      next_sample = 1'b0;
    end
    check_status("t1");
    drain("t1");

    // rate 64, 8-bit mono: every other tick captured
    set_en(1'b0);
    mode_16bit = 1'b0; mode_stereo = 1'b0; sample_rate = 8'd64;
    set_en(1'b1);
    for (int k = 1; k <= 8; k++) tick(16'h8000 + 16'(k), 16'($urandom), 1'b0);
    chk("t2_level4", fifo_level, 4);
    check_status("t2");
    drain("t2");
    sample_rate = 8'd0;
    for (int k = 1; k <= 8; k++) tick(16'($urandom), 16'($urandom), 1'b0);
    chk("t2_rate0_level", fifo_level, 0);
    check_status("t2z");

    // 16-bit stereo into a depth-8 FIFO: third frame dropped whole
    flush();
    sample_rate = 8'd128; mode_16bit = 1'b1; mode_stereo = 1'b1;
    for (int k = 0; k < 3; k++) tick(16'($urandom), 16'($urandom), 1'b0);
    chk("t3_level8", fifo_level, 8);
    chk("t3_full", fifo_full, 1);
    chk("t3_ovf", overflow, 1);
    check_status("t3");
    drain("t3");

    // level 7 then 2-byte frame is dropped; after one pop it fits
    flush();
    mode_16bit = 1'b0; mode_stereo = 1'b0;
    for (int k = 0; k < 7; k++) tick(16'($urandom), 16'($urandom), 1'b0);
    chk("t4_level7", fifo_level, 7);
    mode_stereo = 1'b1;
    tick(16'($urandom), 16'($urandom), 1'b0);
    chk("t4_drop_ovf", overflow, 1);
    chk("t4_drop_level", fifo_level, 7);
    fifo_read = 1'b1;
    @(posedge clk); #1;
    fifo_read = 1'b0;
    chk("t4_pop_level", fifo_level, 6);
    tick(16'($urandom), 16'($urandom), 1'b0);
    chk("t4_fit_level", fifo_level, 8);
    check_status("t4");
    drain("t4");

    // fifo_reset in t+3 of a 4-byte frame (overflow still set from before)
    mode_16bit = 1'b1; mode_stereo = 1'b1;
    left_in = 16'h5A3C; right_in = 16'h96E1; next_sample = 1'b1;
    model_tick();
    @(posedge clk); #1; next_sample = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    fifo_reset = 1'b1;
    exp_q.delete(); movf = 1'b0;
    @(posedge clk); #1;
    fifo_reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_level0", fifo_level, 0);
    chk("t6_ovf0", overflow, 0);
    chk("t6_empty", fifo_empty, 1);
    tick(16'($urandom), 16'($urandom), 1'b0);
    check_status("t6");
    drain("t6");

    // continuous reads during 16-bit stereo writes
    flush();
    fifo_read = 1'b1;
    left_in = 16'h1234; right_in = 16'hABCD; next_sample = 1'b1;
    model_tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_level_le1", (fifo_level <= 1) ? 1 : int'(fifo_level), 1);
      @(posedge clk); #1;
      next_sample = 1'b0;
    end
    fifo_read = 1'b0;
    chk("t5_all_read", exp_q.size(), 0);
    chk("t5_empty", fifo_empty, 1);

    // rst_n asserted mid-frame
    left_in = 16'h5A5A; right_in = 16'h7E7E; next_sample = 1'b1;
    model_tick();
    @(posedge clk); #1; next_sample = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete(); movf = 1'b0; macc = 0;
    check_reset_values("t7");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t7_no_late_write", fifo_level, 0);

    // randomized phase: random rates, modes, data, mid-frame mode changes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0:       sample_rate = 8'd128;
        1:       sample_rate = 8'd64;
        2:       sample_rate = 8'd0;
        3:       sample_rate = 8'd200;
        default: sample_rate = 8'($urandom);
      endcase
      tick(16'($urandom), 16'($urandom), 1'b1);
      check_status("rnd");
      if ($urandom_range(0, 3) == 0) drain("rnd");
      if ($urandom_range(0, 9) == 0) flush();
    end
    drain("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
